// File: rtl/board_poller.sv
`default_nettype none
// ============================================================================
// Module   : board_poller
// Brief    : Enables the keypad scanner over its bus, polls the key-code
//            register, debounces each sample and queues new codes in a FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module board_poller #(
  parameter int                 tamPro    = 16,
  parameter int                 tamAddr   = 4,
  parameter int                 POLL_DIV  = 1000,
  parameter int                 DEBOUNCE  = 2,
  parameter logic [tamAddr-1:0] ADDR_N    = 4'h0,
  parameter logic [tamAddr-1:0] ADDR_INIT = 4'h2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  output logic [tamAddr-1:0] addr,
  output logic               cs,
  output logic               rd,
  output logic               wr,
  output logic [tamPro-1:0]  dout,
  input  logic [tamPro-1:0]  din,
  output logic [3:0]         key_code,
  output logic               key_valid,
  input  logic               key_ack,
  output logic               overflow
);

  localparam int                 CNT_W    = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(POLL_DIV - 1);
  localparam logic [2:0]         DEB      = 3'(DEBOUNCE);

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_INIT_WR = 3'd1,
    ST_WAIT    = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_EVAL    = 3'd4,
    ST_STOP_WR = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         sample_q, sample_d;
  logic [3:0]         prev_q, prev_d;
  logic [2:0]         stable_q, stable_d;
  logic [3:0]         rep_q, rep_d;
  logic               rep_valid_q, rep_valid_d;
  logic               push_req;

  logic [tamAddr-1:0] addr_q, addr_d;
  logic               cs_q, cs_d, rd_q, rd_d, wr_q, wr_d;
  logic [tamPro-1:0]  dout_q, dout_d;

  logic [3:0]         mem_q [4];
  logic [3:0]         mem_d [4];
  logic [1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]         count_q, count_d;
  logic [3:0]         key_code_q, key_code_d;
  logic               key_valid_q, key_valid_d;
  logic               ovf_q, ovf_d;
  logic               pop_ok, push_ok;

  logic               unused_din;
  assign unused_din = ^din[tamPro-1:4];

  // Sequencing and debounce
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sample_d    = sample_q;
    prev_d      = prev_q;
    stable_d    = stable_q;
    rep_d       = rep_q;
    rep_valid_d = rep_valid_q;
    push_req    = 1'b0;
    case (state_q)
      ST_OFF: if (enable) state_d = ST_INIT_WR;
      ST_INIT_WR: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        if (!enable)                 state_d = ST_STOP_WR;
        else if (cnt_q == CNT_LAST)  state_d = ST_RD_REQ;
        else                         cnt_d   = cnt_q + 1'b1;
      end
      ST_RD_REQ: begin
        sample_d = din[3:0];
        state_d  = ST_EVAL;
      end
      ST_EVAL: begin
        if (sample_q == prev_q) stable_d = (stable_q >= DEB) ? DEB : stable_q + 3'd1;
        else                    stable_d = 3'd1;
        prev_d = sample_q;
        if (stable_d == DEB && (!rep_valid_q || sample_q != rep_q)) begin
          push_req    = 1'b1;
          rep_d       = sample_q;
          rep_valid_d = 1'b1;
        end
        cnt_d   = '0;
        state_d = enable ? ST_WAIT : ST_STOP_WR;
      end
      ST_STOP_WR: begin
        rep_valid_d = 1'b0;
        stable_d    = 3'd0;
        state_d     = ST_OFF;
      end
      default: state_d = ST_OFF;
    endcase
  end

  // Bus outputs are decoded from the next state so they register in step with it
  always_comb begin
    addr_d = '0;
    cs_d   = 1'b0;
    rd_d   = 1'b0;
    wr_d   = 1'b0;
    dout_d = '0;
    case (state_d)
      ST_INIT_WR: begin
        addr_d = ADDR_INIT;
        cs_d   = 1'b1;
        wr_d   = 1'b1;
        dout_d = tamPro'(1);
      end
      ST_RD_REQ: begin
        addr_d = ADDR_N;
        cs_d   = 1'b1;
        rd_d   = 1'b1;
      end
      ST_STOP_WR: begin
        addr_d = ADDR_INIT;
        cs_d   = 1'b1;
        wr_d   = 1'b1;
      end
      default: ;
    endcase
  end

  // FIFO: a full FIFO still takes a push when the head is popped in the same cycle
  always_comb begin
    pop_ok   = key_ack && (count_q != 3'd0);
    push_ok  = push_req && ((count_q != 3'd4) || pop_ok);
    mem_d    = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = sample_q;
    wr_ptr_d    = wr_ptr_q + {1'b0, push_ok};
    rd_ptr_d    = rd_ptr_q + {1'b0, pop_ok};
    count_d     = count_q + {2'b00, push_ok} - {2'b00, pop_ok};
    key_code_d  = mem_d[rd_ptr_d];
    key_valid_d = (count_d != 3'd0);
    ovf_d       = ovf_q | (push_req & ~push_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_OFF;
      cnt_q       <= '0;
      sample_q    <= 4'h0;
      prev_q      <= 4'h0;
      stable_q    <= 3'd0;
      rep_q       <= 4'h0;
      rep_valid_q <= 1'b0;
      addr_q      <= '0;
      cs_q        <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      dout_q      <= '0;
      mem_q       <= '{default: 4'h0};
      wr_ptr_q    <= 2'd0;
      rd_ptr_q    <= 2'd0;
      count_q     <= 3'd0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sample_q    <= sample_d;
      prev_q      <= prev_d;
      stable_q    <= stable_d;
      rep_q       <= rep_d;
      rep_valid_q <= rep_valid_d;
      addr_q      <= addr_d;
      cs_q        <= cs_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      dout_q      <= dout_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign addr      = addr_q;
  assign cs        = cs_q;
  assign rd        = rd_q;
  assign wr        = wr_q;
  assign dout      = dout_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign overflow  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_board_poller.sv
`default_nettype none
// ============================================================================
// Module   : tb_board_poller
// Brief    : Scoreboard bench for board_poller with a peripheral stand-in.
// Revision : 1.0 - initial release
// ============================================================================
module tb_board_poller;

  localparam int POLL_DIV = 4;
  localparam int DEBOUNCE = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        key_ack = 1'b0;
  logic [15:0] din = 16'h0;
  logic [3:0]  addr;
  logic        cs, rd, wr;
  logic [15:0] dout;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        overflow;

  board_poller #(
    .tamPro(16), .tamAddr(4), .POLL_DIV(POLL_DIV), .DEBOUNCE(DEBOUNCE),
    .ADDR_N(4'h0), .ADDR_INIT(4'h2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .addr(addr), .cs(cs), .rd(rd),
    .wr(wr), .dout(dout), .din(din), .key_code(key_code), .key_valid(key_valid),
    .key_ack(key_ack), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference state: peripheral code stream, session history, expected FIFO
  int         code_q[$];
  logic [3:0] hold_code = 4'h0;
  logic [3:0] sess[$];
  logic [3:0] mfifo[$];
  bit         mov = 1'b0;
  bit         rep_valid = 1'b0;
  logic [3:0] rep = 4'h0;
  bit         pend_valid = 1'b0;
  int         pend_stage = 0;
  logic [3:0] pend_code = 4'h0;
  bit         ack_seen = 1'b0;
  bit         ack_rand = 1'b0;
  bit         ack_force = 1'b0;
  int         cyc = 0;
  int         last_rd = 0;
  bit         last_rd_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    ack_seen = key_ack;
  end

  initial forever begin
    @(negedge clk);
    key_ack = ack_rand ? 1'($urandom_range(0, 1)) : ack_force;
  end

  // Peripheral stand-in and scoreboard monitor
  initial begin
    bit same;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        mfifo.delete();
        sess.delete();
        mov = 1'b0;
        rep_valid = 1'b0;
        pend_valid = 1'b0;
        last_rd_valid = 1'b0;
      end else begin
        if (ack_seen && mfifo.size() > 0) void'(mfifo.pop_front());
        if (pend_valid) begin
          if (pend_stage == 1) begin
            if (mfifo.size() < 4) mfifo.push_back(pend_code);
            else mov = 1'b1;
            pend_valid = 1'b0;
          end else begin
            pend_stage++;
          end
        end
        check("key_valid", key_valid, mfifo.size() > 0);
        if (mfifo.size() > 0) check("key_code", key_code, mfifo[0]);
        check("overflow", overflow, mov);
        check("bus_excl", !(rd && wr) && (!(rd || wr) || cs), 1);
        if (!cs) begin
          check("idle_addr", addr, 0);
          check("idle_dout", dout, 0);
        end
        if (cs && rd) begin
          check("rd_addr", addr, 0);
          if (code_q.size() > 0) hold_code = 4'(code_q.pop_front());
          din = {12'($urandom()), hold_code};
          if (last_rd_valid) check("poll_period", cyc - last_rd, POLL_DIV + 2);
          last_rd = cyc;
          last_rd_valid = 1'b1;
          sess.push_back(hold_code);
          if (sess.size() >= DEBOUNCE) begin
            same = 1'b1;
            for (int k = 1; k < DEBOUNCE; k++)
              if (sess[sess.size() - 1 - k] != hold_code) same = 1'b0;
            if (same && (!rep_valid || rep != hold_code)) begin
              pend_valid = 1'b1;
              pend_stage = 0;
              pend_code  = hold_code;
              rep        = hold_code;
              rep_valid  = 1'b1;
            end
          end
        end
        if (cs && wr) begin
          check("wr_addr", addr, 2);
          last_rd_valid = 1'b0;
          if (dout != 16'h0001) begin
            check("stop_dout", dout, 0);
            sess.delete();
            rep_valid = 1'b0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_rd(input int n);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      do begin
        tick();
        t++;
      end while (!(cs && rd) && t < 60);
      if (!(cs && rd)) begin
        tests++;
        fails++;
        $display("FAIL rd_timeout: actual=no_read required=read within 60 cycles");
      end
    end
  endtask

  task automatic load(input int vals[]);
    foreach (vals[i]) code_q.push_back(vals[i]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int t;
    int total;
    rst_n = 1'b0;
    tick();
    check("rst_addr", addr, 0);
    check("rst_cs", cs, 0);
    check("rst_rd", rd, 0);
    check("rst_wr", wr, 0);
    check("rst_dout", dout, 0);
    check("rst_key_code", key_code, 0);
    check("rst_key_valid", key_valid, 0);
    check("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    tick();

    // Enable, init write, first read; then debounce and code change
    load('{5, 5, 7, 5, 5, 5, 5, 3, 3, 9, 9});
    enable = 1'b1;
    tick();
    check("init_addr", addr, 2);
    check("init_cs", cs, 1);
    check("init_wr", wr, 1);
    check("init_rd", rd, 0);
    check("init_dout", dout, 16'h0001);
    t = 0;
    do begin
      tick();
      t++;
    end while (!(cs && rd) && t < 60);
    check("first_rd_delay", t, POLL_DIV + 1);
    wait_rd(10);
    repeat (3) tick();
    check("fifo_head_5", key_code, 5);
    ack_force = 1'b1;
    repeat (4) tick();
    ack_force = 1'b0;
    repeat (2) tick();
    check("empty_after_acks", key_valid, 0);
    load('{1, 1});
    wait_rd(2);
    repeat (3) tick();
    check("single_after_extra_ack", key_code, 1);
    ack_force = 1'b1;
    tick();
    ack_force = 1'b0;
    repeat (2) tick();
    check("empty_again", key_valid, 0);

    // Disable during WAIT, then re-enable reports the same code again
    wait_rd(1);
    repeat (2) tick();
    enable = 1'b0;
    tick();
    check("stop_addr", addr, 2);
    check("stop_wr", wr, 1);
    check("stop_cs", cs, 1);
    check("stop_dout_zero", dout, 0);
    tick();
    check("off_cs", cs, 0);
    repeat (3) tick();
    enable = 1'b1;
    wait_rd(3);
    repeat (3) tick();
    check("rereport_valid", key_valid, 1);
    check("rereport_code", key_code, 1);
    ack_force = 1'b1;
    tick();
    ack_force = 1'b0;

    // Overflow with no acks
    enable = 1'b0;
    repeat (3) tick();
    do_reset();
    load('{1, 1, 2, 2, 3, 3, 4, 4, 6, 6});
    enable = 1'b1;
    wait_rd(10);
    repeat (3) tick();
    check("ovf_set", overflow, 1);
    check("ovf_head", key_code, 1);
    ack_force = 1'b1;
    repeat (5) tick();
    ack_force = 1'b0;

    // Push coinciding with a pop while full
    enable = 1'b0;
    repeat (3) tick();
    do_reset();
    load('{1, 1, 2, 2, 3, 3, 4, 4, 6, 6});
    enable = 1'b1;
    wait_rd(10);
    ack_force = 1'b1;
    tick();
    ack_force = 1'b0;
    repeat (3) tick();
    check("full_pushpop_ovf", overflow, 0);
    check("full_pushpop_head", key_code, 2);
    ack_force = 1'b1;
    repeat (5) tick();
    ack_force = 1'b0;

    // Randomized codes and acks with one disable in the middle
    enable = 1'b0;
    repeat (3) tick();
    do_reset();
    total = 0;
    for (int i = 0; i < 25; i++) begin
      int v = $urandom_range(0, 15);
      int r = $urandom_range(1, 3);
      for (int j = 0; j < r; j++) code_q.push_back(v);
      total += r;
    end
    ack_rand = 1'b1;
    enable = 1'b1;
    wait_rd(total / 2);
    repeat (2) tick();
    enable = 1'b0;
    repeat (4) tick();
    enable = 1'b1;
    wait_rd(total - total / 2);
    repeat (4) tick();
    ack_rand = 1'b0;
    ack_force = 1'b0;

    // Asynchronous reset in the middle of a read
    wait_rd(1);
    enable = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_rst_cs", cs, 0);
    check("async_rst_rd", rd, 0);
    check("async_rst_valid", key_valid, 0);
    check("async_rst_code", key_code, 0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("after_rst_valid", key_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/board_poller.md
# board_poller

Bus-initiator companion to the keypad peripheral: drives the peripheral's `cs`/`rd`/`wr`/`addr`/`din` bus side to start the scanner, then polls the key-code register at a programmable rate. Each sample is debounced, and every new stable code is queued into a 4-entry FIFO for downstream logic. It replaces software polling when the keypad peripheral sits on a bus with no CPU.

## Interface
Parameters:
- `tamPro`, 16, bus data width (matches peripheral)
- `tamAddr`, 4, bus address width
- `POLL_DIV`, 1000, clk cycles between read transactions (≥ 4)
- `DEBOUNCE`, 2, consecutive identical samples required to accept a code (1..7)
- `ADDR_N`, 4'h0, key-code register address
- `ADDR_INIT`, 4'h2, scanner-enable register address

Ports:
- `clk` in 1: single clock, all state on posedge
- `rst_n` in 1: asynchronous, active-low reset
- `enable` in 1: level; high runs the scanner and polling
- `addr` out `tamAddr`: bus address
- `cs` out 1: bus chip select
- `rd` out 1: bus read strobe
- `wr` out 1: bus write strobe
- `dout` out `tamPro`: write data to peripheral `din`
- `din` in `tamPro`: read data from peripheral `dout`; only `[3:0]` used
- `key_code` out 4: FIFO head
- `key_valid` out 1: FIFO not empty
- `key_ack` in 1: pop head when `key_valid`
- `overflow` out 1: sticky, set when a code is dropped because the FIFO is full

## Operation
- FSM states: OFF, INIT_WR, WAIT, RD_REQ, EVAL, STOP_WR.
- **OFF**
  - Bus idle: `cs=rd=wr=0`, `addr=0`, `dout=0`.
  - Goes to INIT_WR when `enable=1`.
- **INIT_WR** (1 cycle)
  - Drives `addr=ADDR_INIT`, `cs=1`, `wr=1`, `dout=1`.
  - Then goes to WAIT with the poll counter cleared.
- **WAIT**
  - Counts 0..`POLL_DIV-1`; bus idle.
  - At terminal count goes to RD_REQ.
  - If `enable=0`, goes to STOP_WR instead, with priority over the terminal count.
- **RD_REQ** (1 cycle)
  - Drives `addr=ADDR_N`, `cs=1`, `rd=1`.
  - The peripheral updates its output on the negedge inside this cycle.
  - `din[3:0]` is captured into `sample` on the posedge that ends RD_REQ.
  - Next state is EVAL.
- **EVAL** (1 cycle, bus idle)
  - If `sample == prev`: `stable_cnt` increments, saturating at `DEBOUNCE`. Otherwise `stable_cnt=1`.
  - Then `prev <= sample`.
  - When `stable_cnt` reaches `DEBOUNCE` in this cycle and (`reported_valid==0` or `sample != reported`):
    - push `sample`;
    - `reported <= sample`, `reported_valid <= 1`.
  - Returns to WAIT with the counter cleared, or to STOP_WR if `enable=0`.
- **STOP_WR** (1 cycle)
  - Drives `addr=ADDR_INIT`, `cs=1`, `wr=1`, `dout=0`.
  - Clears `reported_valid` and `stable_cnt`.
  - Next state is OFF.
- `enable` falling during INIT_WR or RD_REQ: the current transaction completes first. RD_REQ still passes through EVAL.
- Bus strobes are mutually exclusive. At most one of `rd`/`wr` is high, and only with `cs=1`.
- **FIFO**
  - 4 entries × 4 bits; 2-bit read and write pointers that wrap; 3-bit count.
  - Pop is accepted only when count > 0. Push is accepted when count < 4, or when count == 4 and a pop occurs in the same cycle.
  - Push and pop in the same cycle leaves count unchanged.
  - A rejected push sets `overflow`. The dropped code still updates `reported`.
  - `key_ack` with an empty FIFO is ignored.

## Timing
- **Reset** (async, immediate on `rst_n` low):
  - state OFF; `addr=0`, `cs=rd=wr=0`, `dout=0`;
  - FIFO empty, so `key_valid=0` and `key_code=0`;
  - `overflow=0`, `stable_cnt=0`, `prev=0`, `reported_valid=0`.
  - Reset mid-transaction drops the strobe immediately; no stop write is issued.
- All outputs are registered.
- INIT_WR is asserted the cycle after `enable` is sampled high in OFF.
- **Poll period:** `POLL_DIV + 2` cycles between consecutive RD_REQ assertions (WAIT `POLL_DIV`, RD_REQ 1, EVAL 1).
- **Push latency:** the pushed code appears as `key_valid=1` one cycle after EVAL. A stable code is visible `DEBOUNCE` poll periods after it first appears, worst case.
- `key_code` reflects the new head the cycle after a pop.

## Test plan
- **Reset and enable:** reset, then `enable=1` → one cycle with `addr=2`, `cs=1`, `wr=1`, `dout=16'h0001`; then the first RD_REQ after `POLL_DIV` cycles. All outputs are 0 during reset.
- **Debounce** (`DEBOUNCE=2`, small `POLL_DIV`): peripheral returns 5, 5 → one push of 5 after the second read. Returns 5, 7, 5 → no push of 7. Returns 5, 5, 5, 5 → exactly one push.
- **Code change:** stable 3 then stable 9 → FIFO holds 3, 9 in order. Ack twice → `key_valid` returns to 0. An extra ack on the empty FIFO leaves count at 0.
- **Overflow:** 5 distinct stable codes with no acks → FIFO holds the first 4 and `overflow=1`. Push coinciding with an ack at full → accepted, no overflow.
- **Disable mid-run:** drop `enable` during WAIT → next cycle `addr=2`, `wr=1`, `dout=0`, then OFF. Re-enable → the first stable code is reported again, even if equal to the last one reported.
- **Async reset during RD_REQ** → `cs`/`rd` drop without a clock edge; FIFO is empty afterward.
